dfd_frame_request_sequencer: RTL and testbench
==============================================

// Module: dfd_frame_request_sequencer
// PURPOSE
// Sequences packet-space requests into the frame filler / accumulator path.
// Round-robin arbitrates NUM_REQ trace packet sources into a single request slot.
// Runs the flush sequence: drains the slot, holds flush_mode_enable, issues flush packets
// until the filler reports frame closure (flush_mode_exit), then resumes arbitration.
// PARAMETERS
// NUM_REQ                4    number of packet sources (>=2)
// PACKET_WIDTH_IN_BYTES  10   max packet size; PW = $clog2(PACKET_WIDTH_IN_BYTES)
// FLUSH_PKT_BYTES        2    size of each flush packet request (1..PACKET_WIDTH_IN_BYTES)
// FLUSH_MAX_PKTS         64   flush packets granted before flush abort (timeout)
// PORTS
// clock                     in   1            sole clock
// reset                     in   1            one clock; reset is synchronous and active-high
// req_valid                 in   NUM_REQ      source i has a packet pending
// req_bytes                 in   NUM_REQ*(PW+1) packed packet sizes, source i at [i*(PW+1)+:PW+1]
// req_grant                 out  NUM_REQ      1-cycle pulse: source i captured into slot (pop)
// request_packet_space_in_bytes out PW+1     slot size to filler; 0 when slot empty
// request_is_flush          out  1            slot holds a flush packet
// requested_packet_space_granted_from_accumulator in 1  accumulator accepted slot this cycle
// flush_req                 in   1            1-cycle flush request pulse
// flush_mode_enable         out  1            to filler: flush tracking active
// flush_mode_exit           in   1            from filler: last packet in frame sent
// flush_busy                out  1            flush in progress (state != ARB)
// flush_done                out  1            1-cycle pulse: flush closed normally
// flush_timeout             out  1            1-cycle pulse: flush aborted at FLUSH_MAX_PKTS
// BEHAVIOUR
// Reset: state=ARB, slot empty (size 0, is_flush 0), rr_ptr=0, flush_cnt=0; all outputs 0.
// Slot: registered; request_packet_space_in_bytes/request_is_flush driven directly from it.
// - Accumulator grant with slot empty is ignored (assertion).
// - Grant clears slot same cycle; refill allowed same cycle (back-to-back, no bubble in ARB).
// Arbitration (ARB only): eligible = req_valid[i] && req_bytes[i]!=0.
// - Slot loads when empty or granted this cycle and any eligible source exists.
// - Winner = first eligible at index rr_ptr, rr_ptr+1, ... mod NUM_REQ.
// - Load: slot<=req_bytes[w], req_grant[w]=1 same cycle (combinational pulse), rr_ptr<=w+1 mod NUM_REQ.
// - Latency: req_valid -> slot visible next cycle.
// - req_bytes > PACKET_WIDTH_IN_BYTES is illegal (assertion).
// FSM:
// - ARB: flush_req=1 -> DRAIN (same cycle, no capture that cycle).
// - DRAIN: no capture; slot empty (or granted this cycle) -> FILL.
// - FILL: slot<=FLUSH_PKT_BYTES, is_flush=1 held; on grant clear slot, flush_cnt++ -> WAIT.
// - WAIT: slot empty. flush_mode_exit=1 -> DONE.
//   Else if flush_cnt==FLUSH_MAX_PKTS -> ABORT, else -> FILL.
// - Bubble in WAIT is mandatory: filler's exit flag lags the closing grant by 1 cycle.
// - DONE: flush_done=1 one cycle; flush_cnt<=0 -> ARB.
// - ABORT: flush_timeout=1 one cycle; flush_cnt<=0 -> ARB.
// flush_mode_enable = state in {DRAIN,FILL,WAIT}; deasserts in DONE/ABORT cycle.
// flush_busy = state != ARB. flush_req pulses while flush_busy are dropped, not queued.
// flush_mode_exit outside WAIT is ignored.
// Reset mid-flush: immediate return to reset values; no done/timeout pulse.
// flush_cnt width $clog2(FLUSH_MAX_PKTS+1); saturates, never wraps.
// TESTING
// All 4 valid, bytes 3,5,7,9, grant every cycle -> grants 0,1,2,3,0 in order; slot 3,5,7,9; no bubble.
// Source 2 only, rr_ptr=3 -> winner 2; next winner search starts at 3.
// req_bytes=0 on valid source 1 -> never granted; other sources unaffected.
// Slot 6 pending, flush_req -> DRAIN until grant; FILL slot=2, is_flush=1, flush_mode_enable=1.
// Flush: exit on 3rd flush grant + 1 -> flush_done pulse; ARB resumes, enable drops.
// flush_mode_exit never asserts, FLUSH_MAX_PKTS=4 -> 4 flush grants, flush_timeout pulse, ARB.
// reset in WAIT -> next cycle all outputs 0, state ARB.

Source files
------------

// File: rtl/dfd_frame_request_sequencer.sv
// Round-robin request slot for the frame filler, with a flush sequencer that drains the slot
// and issues flush packets until the filler closes the frame or the packet budget runs out.
module dfd_frame_request_sequencer #(
    parameter int NUM_REQ               = 4,
    parameter int PACKET_WIDTH_IN_BYTES = 10,
    parameter int FLUSH_PKT_BYTES       = 2,
    parameter int FLUSH_MAX_PKTS        = 64,
    localparam int PW                   = $clog2(PACKET_WIDTH_IN_BYTES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*(PW+1)-1:0]   req_bytes,
    output logic [NUM_REQ-1:0]          req_grant,
    output logic [PW:0]                 request_packet_space_in_bytes,
    output logic                        request_is_flush,
    input  logic                        requested_packet_space_granted_from_accumulator,
    input  logic                        flush_req,
    output logic                        flush_mode_enable,
    input  logic                        flush_mode_exit,
    output logic                        flush_busy,
    output logic                        flush_done,
    output logic                        flush_timeout
);

    localparam int BW = PW + 1;
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(FLUSH_MAX_PKTS + 1);
    localparam logic [BW-1:0] FLUSH_BYTES = BW'(FLUSH_PKT_BYTES);
    localparam logic [CW-1:0] CNT_MAX     = CW'(FLUSH_MAX_PKTS);
    localparam logic [RW:0]   NR_WIDE     = (RW+1)'(NUM_REQ);
    localparam logic [RW-1:0] RR_LAST     = RW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_ARB   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_FILL  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ABORT = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [BW-1:0]   slot_bytes_r;
    logic            slot_flush_r;
    logic [RW-1:0]   rr_ptr_r;
    logic [CW-1:0]   flush_cnt_r;
    logic            flush_en_r;
    logic            flush_busy_r;
    logic            flush_done_r;
    logic            flush_timeout_r;

    logic [BW-1:0]   bytes_s [NUM_REQ];
    logic [NUM_REQ-1:0] eligible_s;
    logic [RW-1:0]   winner_s;
    logic            found_s;
    logic            acc_take_s;
    logic            slot_free_s;
    logic            load_s;
    logic            enter_fill_s;
    logic [RW-1:0]   rr_next_s;

    // Unpack source sizes and flag sources that have a non-empty packet pending
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bytes_s[i]    = req_bytes[i*BW +: BW];
            eligible_s[i] = req_valid[i] && (bytes_s[i] != '0);
        end
    end

    // Round-robin search starting at rr_ptr_r
    always_comb begin
        logic [RW:0]   sum_v;
        logic [RW-1:0] idx_v;
        logic          take_v;
        found_s  = 1'b0;
        winner_s = '0;
        sum_v    = '0;
        idx_v    = '0;
        take_v   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v    = {1'b0, rr_ptr_r} + (RW+1)'(k);
            idx_v    = (sum_v >= NR_WIDE) ? RW'(sum_v - NR_WIDE) : RW'(sum_v);
            take_v   = !found_s && eligible_s[idx_v];
            winner_s = take_v ? idx_v : winner_s;
            found_s  = found_s | take_v;
        end
    end

    // An accumulator grant only counts when the slot actually holds something
    assign acc_take_s   = requested_packet_space_granted_from_accumulator && (slot_bytes_r != '0);
    assign slot_free_s  = (slot_bytes_r == '0) || acc_take_s;
    assign load_s       = !reset && (state_r == ST_ARB) && !flush_req && slot_free_s && found_s;
    assign enter_fill_s = (state_next_s == ST_FILL) && (state_r != ST_FILL);
    assign rr_next_s    = (winner_s == RR_LAST) ? '0 : winner_s + RW'(1);

    // One-hot pop pulse to the winning source in the cycle it is captured
    always_comb begin
        req_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_grant[i] = load_s && (winner_s == RW'(i));
        end
    end

    // Flush sequencer next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ARB:   state_next_s = flush_req   ? ST_DRAIN : ST_ARB;
            ST_DRAIN: state_next_s = slot_free_s ? ST_FILL  : ST_DRAIN;
            ST_FILL:  state_next_s = acc_take_s  ? ST_WAIT  : ST_FILL;
            ST_WAIT: begin
                // The bubble here gives the filler's exit flag time to catch up with the last grant
                if (flush_mode_exit) begin
                    state_next_s = ST_DONE;
                end else if (flush_cnt_r == CNT_MAX) begin
                    state_next_s = ST_ABORT;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DONE:  state_next_s = ST_ARB;
            ST_ABORT: state_next_s = ST_ARB;
            default:  state_next_s = ST_ARB;
        endcase
    end

    // State, request slot, round-robin pointer, flush counter and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_ARB;
            slot_bytes_r    <= '0;
            slot_flush_r    <= 1'b0;
            rr_ptr_r        <= '0;
            flush_cnt_r     <= '0;
            flush_en_r      <= 1'b0;
            flush_busy_r    <= 1'b0;
            flush_done_r    <= 1'b0;
            flush_timeout_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            flush_en_r      <= (state_next_s == ST_DRAIN) || (state_next_s == ST_FILL) ||
                               (state_next_s == ST_WAIT);
            flush_busy_r    <= (state_next_s != ST_ARB);
            flush_done_r    <= (state_next_s == ST_DONE);
            flush_timeout_r <= (state_next_s == ST_ABORT);

            if (enter_fill_s) begin
                slot_bytes_r <= FLUSH_BYTES;
                slot_flush_r <= 1'b1;
            end else if (load_s) begin
                slot_bytes_r <= bytes_s[winner_s];
                slot_flush_r <= 1'b0;
            end else if (acc_take_s) begin
                slot_bytes_r <= '0;
                slot_flush_r <= 1'b0;
            end

            if (load_s) begin
                rr_ptr_r <= rr_next_s;
            end

            if ((state_r == ST_DONE) || (state_r == ST_ABORT)) begin
                flush_cnt_r <= '0;
            end else if ((state_r == ST_FILL) && acc_take_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CW'(1);
            end
        end
    end

    assign request_packet_space_in_bytes = slot_bytes_r;
    assign request_is_flush              = slot_flush_r;
    assign flush_mode_enable             = flush_en_r;
    assign flush_busy                    = flush_busy_r;
    assign flush_done                    = flush_done_r;
    assign flush_timeout                 = flush_timeout_r;

    dfd_frame_request_sequencer_chk #(
        .NUM_REQ               (NUM_REQ),
        .PACKET_WIDTH_IN_BYTES (PACKET_WIDTH_IN_BYTES),
        .BW                    (BW)
    ) u_chk (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_bytes  (req_bytes),
        .slot_bytes (slot_bytes_r),
        .acc_grant  (requested_packet_space_granted_from_accumulator)
    );

endmodule

// Interface-legality checks: no accumulator grant on an empty slot, no oversize packet requests.
module dfd_frame_request_sequencer_chk #(
    parameter int NUM_REQ               = 4,
    parameter int PACKET_WIDTH_IN_BYTES = 10,
    parameter int BW                    = 5
) (
    input logic                    clock,
    input logic                    reset,
    input logic [NUM_REQ-1:0]      req_valid,
    input logic [NUM_REQ*BW-1:0]   req_bytes,
    input logic [BW-1:0]           slot_bytes,
    input logic                    acc_grant
);

    a_grant_on_full_slot: assert property (@(posedge clock) disable iff (reset)
        acc_grant |-> (slot_bytes != '0));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_size
        a_size_legal: assert property (@(posedge clock) disable iff (reset)
            req_valid[i] |-> (req_bytes[i*BW +: BW] <= BW'(PACKET_WIDTH_IN_BYTES)));
    end

endmodule

// File: tb/tb_dfd_frame_request_sequencer.sv
// Directed vector bench for dfd_frame_request_sequencer: arbitration order, zero-size skip,
// flush drain/fill/close, flush timeout and reset mid-flush.
module tb_dfd_frame_request_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [19:0] req_bytes;
    logic [3:0]  req_grant;
    logic [4:0]  request_packet_space_in_bytes;
    logic        request_is_flush;
    logic        acc;
    logic        flush_req;
    logic        flush_mode_enable;
    logic        flush_mode_exit;
    logic        flush_busy;
    logic        flush_done;
    logic        flush_timeout;

    always #5 clock = ~clock;

    dfd_frame_request_sequencer #(
        .NUM_REQ               (4),
        .PACKET_WIDTH_IN_BYTES (10),
        .FLUSH_PKT_BYTES       (2),
        .FLUSH_MAX_PKTS        (4)
    ) dut (
        .clock                                           (clock),
        .reset                                           (reset),
        .req_valid                                       (req_valid),
        .req_bytes                                       (req_bytes),
        .req_grant                                       (req_grant),
        .request_packet_space_in_bytes                   (request_packet_space_in_bytes),
        .request_is_flush                                (request_is_flush),
        .requested_packet_space_granted_from_accumulator (acc),
        .flush_req                                       (flush_req),
        .flush_mode_enable                               (flush_mode_enable),
        .flush_mode_exit                                 (flush_mode_exit),
        .flush_busy                                      (flush_busy),
        .flush_done                                      (flush_done),
        .flush_timeout                                   (flush_timeout)
    );

    // ctl = {reset, acc_grant, flush_req, flush_mode_exit}
    // flags = {is_flush, flush_mode_enable, flush_busy, flush_done, flush_timeout}
    typedef struct {
        logic [3:0]  vld;
        logic [19:0] bytes;
        logic [3:0]  ctl;
        logic [3:0]  eg;
        logic [4:0]  es;
        logic [4:0]  ef;
    } vec_t;

    localparam logic [19:0] BA = {5'd9, 5'd7, 5'd5, 5'd3};
    localparam logic [19:0] BC = {5'd9, 5'd7, 5'd0, 5'd3};
    localparam logic [19:0] BD = {5'd9, 5'd7, 5'd5, 5'd6};
    localparam logic [3:0] C0 = 4'b0000, CR = 4'b1000, CA = 4'b0100, CF = 4'b0010;
    localparam logic [3:0] CX = 4'b0001, CAF = 4'b0110, CRX = 4'b1001;
    localparam logic [4:0] O_IDLE = 5'b00000, O_DRAIN = 5'b01100, O_FILL = 5'b11100;
    localparam logic [4:0] O_WAIT = 5'b01100, O_DONE = 5'b00110, O_ABORT = 5'b00101;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [3:0] vld, input logic [19:0] b, input logic [3:0] ctl,
                       input logic [3:0] eg, input logic [4:0] es, input logic [4:0] ef);
        vec_t v;
        v.vld = vld; v.bytes = b; v.ctl = ctl; v.eg = eg; v.es = es; v.ef = ef;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        int  fgr;
        bit  seen;
        reset = 1'b1; req_valid = '0; req_bytes = '0; acc = 1'b0;
        flush_req = 1'b0; flush_mode_exit = 1'b0;
        fgr = 0; seen = 1'b0;

        // reset
        add(4'h0, BA, CR, 4'b0000, 5'd0, O_IDLE);
        add(4'h0, BA, CR, 4'b0000, 5'd0, O_IDLE);
        // all four pending, grant every cycle: 0,1,2,3,0 with no bubble
        add(4'hF, BA, C0, 4'b0001, 5'd3, O_IDLE);
        add(4'hF, BA, CA, 4'b0010, 5'd5, O_IDLE);
        add(4'hF, BA, CA, 4'b0100, 5'd7, O_IDLE);
        add(4'hF, BA, CA, 4'b1000, 5'd9, O_IDLE);
        add(4'hF, BA, CA, 4'b0001, 5'd3, O_IDLE);
        add(4'h0, BA, CA, 4'b0000, 5'd0, O_IDLE);
        // source 2 only, pointer wraps from 3 back to 2; next search starts at 3
        add(4'b0100, BA, C0, 4'b0100, 5'd7, O_IDLE);
        add(4'b0100, BA, CA, 4'b0100, 5'd7, O_IDLE);
        add(4'hF,    BA, CA, 4'b1000, 5'd9, O_IDLE);
        add(4'h0,    BA, CA, 4'b0000, 5'd0, O_IDLE);
        // source 1 valid with zero bytes is skipped
        add(4'hF, BC, C0, 4'b0001, 5'd3, O_IDLE);
        add(4'hF, BC, CA, 4'b0100, 5'd7, O_IDLE);
        add(4'hF, BC, CA, 4'b1000, 5'd9, O_IDLE);
        add(4'hF, BC, CA, 4'b0001, 5'd3, O_IDLE);
        add(4'hF, BC, CA, 4'b0100, 5'd7, O_IDLE);
        add(4'hF, BC, C0, 4'b0000, 5'd7, O_IDLE);
        add(4'h0, BC, CA, 4'b0000, 5'd0, O_IDLE);
        // slot 6 pending, flush: drain, fill, three flush grants, exit closes
        add(4'b0001, BD, C0,  4'b0001, 5'd6, O_IDLE);
        add(4'h0,    BD, CF,  4'b0000, 5'd6, O_DRAIN);
        add(4'b0001, BD, C0,  4'b0000, 5'd6, O_DRAIN);
        add(4'h0,    BD, CA,  4'b0000, 5'd2, O_FILL);
        add(4'h0,    BD, CX,  4'b0000, 5'd2, O_FILL);
        add(4'h0,    BD, CA,  4'b0000, 5'd0, O_WAIT);
        add(4'h0,    BD, C0,  4'b0000, 5'd2, O_FILL);
        add(4'h0,    BD, CA,  4'b0000, 5'd0, O_WAIT);
        add(4'h0,    BD, C0,  4'b0000, 5'd2, O_FILL);
        add(4'h0,    BD, CAF, 4'b0000, 5'd0, O_WAIT);
        add(4'h0,    BD, CX,  4'b0000, 5'd0, O_DONE);
        add(4'b0001, BD, C0,  4'b0000, 5'd0, O_IDLE);
        add(4'b0001, BD, C0,  4'b0001, 5'd6, O_IDLE);
        add(4'h0,    BD, CA,  4'b0000, 5'd0, O_IDLE);
        // no exit: four flush grants then timeout
        add(4'h0, BD, CF, 4'b0000, 5'd0, O_DRAIN);
        add(4'h0, BD, C0, 4'b0000, 5'd2, O_FILL);
        for (int k = 0; k < 4; k++) begin
            add(4'h0, BD, CA, 4'b0000, 5'd0, O_WAIT);
            if (k < 3) add(4'h0, BD, C0, 4'b0000, 5'd2, O_FILL);
        end
        add(4'h0, BD, C0, 4'b0000, 5'd0, O_ABORT);
        add(4'h0, BD, C0, 4'b0000, 5'd0, O_IDLE);
        // reset in WAIT clears everything, pointer back to 0
        add(4'h0, BD, CF,  4'b0000, 5'd0, O_DRAIN);
        add(4'h0, BD, C0,  4'b0000, 5'd2, O_FILL);
        add(4'h0, BD, CA,  4'b0000, 5'd0, O_WAIT);
        add(4'hF, BA, CRX, 4'b0000, 5'd0, O_IDLE);
        add(4'hF, BA, C0,  4'b0001, 5'd3, O_IDLE);

        foreach (vecs[i]) begin
            @(negedge clock);
            {reset, acc, flush_req, flush_mode_exit} = vecs[i].ctl;
            req_valid = vecs[i].vld;
            req_bytes = vecs[i].bytes;
            #1;
            check($sformatf("grant[%0d]", i), 32'(req_grant), 32'(vecs[i].eg));
            @(posedge clock);
            #1;
            check($sformatf("outs[%0d]", i),
                  32'({request_packet_space_in_bytes, request_is_flush, flush_mode_enable,
                       flush_busy, flush_done, flush_timeout}),
                  32'({vecs[i].es, vecs[i].ef}));
        end

        // Reactive accumulator: grant whatever is offered, never exit; expect timeout after 4 flush grants
        @(negedge clock);
        req_valid = '0; acc = 1'b0; flush_mode_exit = 1'b0; flush_req = 1'b1;
        @(posedge clock);
        #1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            flush_req = 1'b0;
            acc = (request_packet_space_in_bytes != 5'd0);
            if (acc && request_is_flush) fgr++;
            @(posedge clock);
            #1;
            if (flush_timeout) seen = 1'b1;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("flush_grants", 32'(fgr), 32'd4);
        @(negedge clock);
        acc = 1'b0;
        @(posedge clock);
        #1;
        check("post_abort", 32'({flush_timeout, flush_busy, flush_mode_enable}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
